// File: rtl/adc_pkg.sv
// ============================================================================
// Module   : adc_pkg
// Purpose  : Shared state encoding, default sizes and width helper for the
//            multi-channel ADC SPI receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        DONE     = 3'd3,
        QUIET    = 3'd4
    } state_t;

    localparam int c_DEF_FRAME_BITS   = 16;
    localparam int c_DEF_DATA_BITS    = 12;
    localparam int c_DEF_CHANNELS     = 2;
    localparam int c_DEF_CLK_DIV      = 4;
    localparam int c_DEF_QUIET_CYCLES = 8;

    // Bits needed to hold 0..value, never less than one.
    function automatic int clog2_min1(input int value);
        return (value < 1) ? 1 : $clog2(value + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sclk_gen.sv
// ============================================================================
// Module   : sclk_gen
// Purpose  : SCLK half-period divider; low phase first, idles high when off.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sclk_gen
    import adc_pkg::*;
#(
    parameter int CLK_DIV = c_DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_strobe,
    output logic o_fall_strobe
);

    localparam int                c_CNT_W = clog2_min1(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_phase;
    logic               w_last;

    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_last) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + c_CNT_W'(1);
        end
    end

    // Strobes flag the cycle whose closing edge flips SCLK.
    assign o_sclk        = i_en ? r_phase : 1'b1;
    assign o_rise_strobe = i_en && !r_phase && w_last;
    assign o_fall_strobe = i_en &&  r_phase && w_last;

endmodule

`default_nettype wire

// File: rtl/adc_spi_rx_multi.sv
// ============================================================================
// Module   : adc_spi_rx_multi
// Purpose  : SPI master/receiver for CHANNELS parallel AD7476-class ADCs.
//            Optional leading-zero frame check: define ADC_LEAD_ZERO_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_spi_rx_multi
    import adc_pkg::*;
#(
    parameter int FRAME_BITS   = c_DEF_FRAME_BITS,
    parameter int DATA_BITS    = c_DEF_DATA_BITS,
    parameter int CHANNELS     = c_DEF_CHANNELS,
    parameter int CLK_DIV      = c_DEF_CLK_DIV,
    parameter int QUIET_CYCLES = c_DEF_QUIET_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           continuous,
    input  logic [CHANNELS-1:0]            SDATA,
    output logic                           CS,
    output logic                           SCLK,
    output logic                           busy,
    output logic                           rx_done_tick,
    output logic [CHANNELS*FRAME_BITS-1:0] b_reg,
    output logic [CHANNELS*DATA_BITS-1:0]  data_Out
`ifdef ADC_LEAD_ZERO_CHECK_EN
    ,
    output logic [CHANNELS-1:0]            frame_err
`endif
);

    localparam int c_CNT_MAX = ((CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES) - 1;
    localparam int c_CNT_W   = clog2_min1(c_CNT_MAX);
    localparam int c_BIT_W   = clog2_min1(FRAME_BITS - 1);

    localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_QUIET_LAST = c_CNT_W'(QUIET_CYCLES - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST   = c_BIT_W'(FRAME_BITS - 1);

    state_t                         r_state;
    state_t                         w_next;
    logic [c_CNT_W-1:0]             r_cnt;
    logic [c_BIT_W-1:0]             r_bit;
    logic                           w_rise;
    logic                           w_bit_end;
    logic                           w_load;
    logic [CHANNELS*FRAME_BITS-1:0] w_sr_flat;

    sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk           (clk),
        .rst           (reset),
        .i_en          (r_state == SHIFT),
        .o_sclk        (SCLK),
        .o_rise_strobe (w_rise),
        .o_fall_strobe (w_bit_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // A start held through the end of QUIET chains like continuous mode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (start) w_next = CS_SETUP;
            CS_SETUP: if (r_cnt == c_SETUP_LAST) w_next = SHIFT;
            SHIFT:    if (w_bit_end && (r_bit == c_BIT_LAST)) w_next = DONE;
            DONE:     w_next = QUIET;
            QUIET:    if (r_cnt == c_QUIET_LAST)
                          w_next = (continuous || start) ? CS_SETUP : IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if ((r_state != w_next) || !((r_state == CS_SETUP) || (r_state == QUIET)))
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + c_CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 r_bit <= '0;
        else if (r_state != SHIFT) r_bit <= '0;
        else if (w_bit_end)        r_bit <= r_bit + c_BIT_W'(1);
    end

    assign w_load       = (r_state == SHIFT) && (w_next == DONE);
    assign CS           = !((r_state == CS_SETUP) || (r_state == SHIFT));
    assign busy         = (r_state != IDLE);
    assign rx_done_tick = (r_state == DONE);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [FRAME_BITS-1:0] r_sr;

        always_ff @(posedge clk or posedge reset) begin
            if (reset)       r_sr <= '0;
            else if (w_rise) r_sr <= (r_sr << 1) | FRAME_BITS'(SDATA[c]);
        end

        assign w_sr_flat[c*FRAME_BITS +: FRAME_BITS] = r_sr;
        assign data_Out[c*DATA_BITS +: DATA_BITS]    = b_reg[c*FRAME_BITS +: DATA_BITS];
    end

    // Published only on a complete frame, so an aborted frame never leaks out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       b_reg <= '0;
        else if (w_load) b_reg <= w_sr_flat;
    end

`ifdef ADC_LEAD_ZERO_CHECK_EN
    if (FRAME_BITS > DATA_BITS) begin : g_lz
        logic [CHANNELS-1:0] w_lz;

        for (genvar c = 0; c < CHANNELS; c++) begin : g_lz_chan
            assign w_lz[c] = |w_sr_flat[c*FRAME_BITS + DATA_BITS +: FRAME_BITS - DATA_BITS];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset)       frame_err <= '0;
            else if (w_load) frame_err <= w_lz;
        end
    end else begin : g_no_lz
        assign frame_err = '0;
    end
`endif

endmodule

`default_nettype wire
